// File: rtl/status_frame_pkg.sv
// Shared definitions for the status frame decoder.
//   CHUNK_W   payload chunk width carried by each received byte
//   TAG_*     byte tags in data_receive[1:0]
//   CHK_SEED  seed folded into the running XOR checksum
//   state_t   frame assembly states
//   rx_byte_t received byte layout {payload, tag}
package status_frame_pkg;

    localparam int unsigned CHUNK_W = 6;

    localparam logic [1:0] TAG_FILL  = 2'b00;
    localparam logic [1:0] TAG_START = 2'b01;
    localparam logic [1:0] TAG_END   = 2'b10;
    localparam logic [1:0] TAG_CONT  = 2'b11;

    localparam logic [CHUNK_W-1:0] CHK_SEED = 6'h2A;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2
    } state_t;

    typedef struct packed {
        logic [CHUNK_W-1:0] payload;
        logic [1:0]         tag;
    } rx_byte_t;

    // One checksum accumulation step.
    function automatic logic [CHUNK_W-1:0] chk_step(input logic [CHUNK_W-1:0] acc,
                                                    input logic [CHUNK_W-1:0] chunk);
        return acc ^ chunk;
    endfunction

endpackage

// File: rtl/rx_idle_timer.sv
// Idle interval timer: counts cycles while run is high, clears on clear.
//   clk, rst  clock, asynchronous active-high reset
//   clear     restart the interval from zero
//   run       count enable
//   expired   high while run is set and LIMIT cycles have elapsed since clear;
//             the count saturates there until cleared
module rx_idle_timer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LIMIT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    logic [WIDTH-1:0] count;

    // Decoded one cycle early so the owner reacts on the LIMIT-th edge.
    assign expired = run && (count == WIDTH'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && !expired) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/status_frame_decoder.sv
// Assembles tagged UART bytes into checksum-protected status frames and
// commits them atomically to the flags register.
//   clk, rst       clock, asynchronous active-high reset
//   data_valid     one-cycle strobe qualifying data_receive
//   data_receive   received byte: [7:2] payload chunk, [1:0] tag
//   flags          last committed status, chunk k at flags[6k+5:6k]
//   feedback_leds  low LED_WIDTH bits of flags
//   frame_ok       pulse: frame committed
//   frame_err      pulse: checksum, timeout or protocol error
//   busy           frame in progress
//   stale          no good frame for STALE_CYCLES
// Build option: define STATUS_STALE_EN to enable the stale timer; without it
// stale stays 0 and flags hold their last committed value indefinitely.
module status_frame_decoder
    import status_frame_pkg::*;
#(
    parameter int unsigned NUM_FLAGS      = 12,
    parameter int unsigned LED_WIDTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned STALE_CYCLES   = 5000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_valid,
    input  logic [7:0]           data_receive,
    output logic [NUM_FLAGS-1:0] flags,
    output logic [LED_WIDTH-1:0] feedback_leds,
    output logic                 frame_ok,
    output logic                 frame_err,
    output logic                 busy,
    output logic                 stale
);

    localparam int unsigned NUM_CHUNKS = (NUM_FLAGS + CHUNK_W - 1) / CHUNK_W;
    localparam int unsigned BUF_W      = NUM_CHUNKS * CHUNK_W;
    localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int unsigned TO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned STALE_W    = $clog2(STALE_CYCLES + 1);

`ifdef STATUS_STALE_EN
    localparam logic STALE_ON = 1'b1;
`else
    localparam logic STALE_ON = 1'b0;
`endif

    state_t             state, state_d;
    rx_byte_t           rx;
    logic [BUF_W-1:0]   chunk_buf;
    logic [CHUNK_W-1:0] acc;
    logic [IDX_W-1:0]   idx;
    logic               byte_c, load_first_c, load_next_c, commit_c, err_c;
    logic               timeout_hit, stale_hit;

    assign rx            = rx_byte_t'(data_receive);
    assign byte_c        = data_valid && (rx.tag != TAG_FILL);
    assign busy          = (state != IDLE);
    assign feedback_leds = flags[LED_WIDTH-1:0];

    // Inter-byte timeout: filler does not restart it, any tagged byte does.
    rx_idle_timer #(.WIDTH(TO_W), .LIMIT(TIMEOUT_CYCLES)) u_byte_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (byte_c || (state == IDLE)),
        .run     (state != IDLE),
        .expired (timeout_hit)
    );

    // Stale timer: runs only when the option is built in, restarts on commit.
    rx_idle_timer #(.WIDTH(STALE_W), .LIMIT(STALE_CYCLES)) u_stale_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (commit_c),
        .run     (STALE_ON),
        .expired (stale_hit)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and datapath controls; a tagged byte takes priority over timeout.
    always_comb begin
        state_d      = state;
        load_first_c = 1'b0;
        load_next_c  = 1'b0;
        commit_c     = 1'b0;
        err_c        = 1'b0;
        case (state)
            IDLE: begin
                if (byte_c && (rx.tag == TAG_START)) begin
                    load_first_c = 1'b1;
                    state_d      = (NUM_CHUNKS == 1) ? CHECK : COLLECT;
                end
            end
            COLLECT: begin
                if (byte_c) begin
                    case (rx.tag)
                        TAG_CONT: begin
                            load_next_c = 1'b1;
                            if (idx == IDX_W'(NUM_CHUNKS - 1)) begin
                                state_d = CHECK;
                            end
                        end
                        TAG_START: begin
                            err_c        = 1'b1;
                            load_first_c = 1'b1;
                            state_d      = (NUM_CHUNKS == 1) ? CHECK : COLLECT;
                        end
                        default: begin
                            err_c   = 1'b1;
                            state_d = IDLE;
                        end
                    endcase
                end else if (timeout_hit) begin
                    err_c   = 1'b1;
                    state_d = IDLE;
                end
            end
            CHECK: begin
                if (byte_c) begin
                    case (rx.tag)
                        TAG_END: begin
                            if (rx.payload == acc) begin
                                commit_c = 1'b1;
                            end else begin
                                err_c = 1'b1;
                            end
                            state_d = IDLE;
                        end
                        TAG_START: begin
                            err_c        = 1'b1;
                            load_first_c = 1'b1;
                            state_d      = (NUM_CHUNKS == 1) ? CHECK : COLLECT;
                        end
                        default: begin
                            err_c   = 1'b1;
                            state_d = IDLE;
                        end
                    endcase
                end else if (timeout_hit) begin
                    err_c   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Chunk buffer and running checksum (seeded so END compares directly).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chunk_buf <= '0;
            acc       <= '0;
            idx       <= '0;
        end else if (load_first_c) begin
            chunk_buf <= BUF_W'(rx.payload);
            acc       <= chk_step(CHK_SEED, rx.payload);
            idx       <= IDX_W'(1);
        end else if (load_next_c) begin
            for (int unsigned k = 0; k < NUM_CHUNKS; k++) begin
                if (idx == IDX_W'(k)) begin
                    chunk_buf[k*CHUNK_W +: CHUNK_W] <= rx.payload;
                end
            end
            acc <= chk_step(acc, rx.payload);
            idx <= idx + IDX_W'(1);
        end
    end

    // Registered status outputs; a commit overrides a simultaneous stale event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags     <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            stale     <= 1'b0;
        end else begin
            frame_ok  <= commit_c;
            frame_err <= err_c;
            if (commit_c) begin
                flags <= chunk_buf[NUM_FLAGS-1:0];
                stale <= 1'b0;
            end else if (stale_hit) begin
                flags <= '0;
                stale <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_status_frame_decoder.sv
// Bench for status_frame_decoder: directed scenarios plus randomized frames
// checked against a chunk-queue reference model.
module tb_status_frame_decoder;

    localparam int NF = 12;
    localparam int LW = 4;
    localparam int TO = 20;
    localparam int SC = 200;
    localparam int NC = 2;

`ifdef STATUS_STALE_EN
    localparam bit STALE_EN = 1'b1;
`else
    localparam bit STALE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          data_valid = 1'b0;
    logic [7:0]    data_receive = 8'h00;
    logic [NF-1:0] flags;
    logic [LW-1:0] feedback_leds;
    logic          frame_ok, frame_err, busy, stale;

    int errors = 0;
    int checks = 0;

    // Reference model: chunks gathered so far (empty = no frame in progress).
    logic [5:0]    q[$];
    logic [NF-1:0] m_flags;
    bit            m_stale;
    int            tcount, scount;
    logic          exp_ok, exp_err, exp_busy, exp_stale;
    logic [NF-1:0] exp_flags;

    status_frame_decoder #(
        .NUM_FLAGS(NF), .LED_WIDTH(LW), .TIMEOUT_CYCLES(TO), .STALE_CYCLES(SC)
    ) dut (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data_receive(data_receive),
        .flags(flags), .feedback_leds(feedback_leds), .frame_ok(frame_ok),
        .frame_err(frame_err), .busy(busy), .stale(stale)
    );

    always #5 clk = ~clk;

    task automatic model_reset;
        q.delete();
        m_flags = '0;
        m_stale = 1'b0;
        tcount  = 0;
        scount  = 0;
        exp_ok = 1'b0; exp_err = 1'b0; exp_busy = 1'b0; exp_stale = 1'b0;
        exp_flags = '0;
    endtask

    // Drive one cycle (from negedge to negedge) and advance the model.
    task automatic step(input logic v, input logic [7:0] b);
        logic [5:0]  pl;
        logic [1:0]  tg;
        logic [5:0]  x;
        logic [47:0] t;
        data_valid   = v;
        data_receive = b;
        @(negedge clk);
        data_valid   = 1'b0;
        data_receive = 8'h00;
        exp_ok  = 1'b0;
        exp_err = 1'b0;
        pl = b[7:2];
        tg = b[1:0];
        if (v && tg != 2'b00) begin
            tcount = 0;
            case (tg)
                2'b01: begin
                    if (q.size() != 0) exp_err = 1'b1;
                    q.delete();
                    q.push_back(pl);
                end
                2'b11: begin
                    if (q.size() != 0) begin
                        if (q.size() < NC) q.push_back(pl);
                        else begin exp_err = 1'b1; q.delete(); end
                    end
                end
                default: begin
                    if (q.size() != 0) begin
                        if (q.size() < NC) exp_err = 1'b1;
                        else begin
                            x = 6'h2A;
                            t = '0;
                            for (int i = 0; i < q.size(); i++) begin
                                x = x ^ q[i];
                                t[i*6 +: 6] = q[i];
                            end
                            if (x == pl) begin
                                exp_ok  = 1'b1;
                                m_flags = t[NF-1:0];
                            end else begin
                                exp_err = 1'b1;
                            end
                        end
                        q.delete();
                    end
                end
            endcase
        end else if (q.size() != 0) begin
            tcount++;
            if (tcount >= TO) begin
                exp_err = 1'b1;
                q.delete();
            end
        end
        if (exp_ok) begin
            scount  = 0;
            m_stale = 1'b0;
        end else begin
            scount++;
            if (STALE_EN && scount >= SC) begin
                m_stale = 1'b1;
                m_flags = '0;
            end
        end
        exp_busy  = (q.size() != 0);
        exp_stale = m_stale;
        exp_flags = m_flags;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (flags !== 12'h000) begin errors++; $display("FAIL reset_flags got=%h exp=000", flags); end
        checks++; if (feedback_leds !== 4'h0) begin errors++; $display("FAIL reset_leds got=%h exp=0", feedback_leds); end
        checks++; if (frame_ok !== 1'b0) begin errors++; $display("FAIL reset_ok got=%b exp=0", frame_ok); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL reset_stale got=%b exp=0", stale); end
    endtask

    task automatic test_good_frame;
        step(1'b1, 8'h05);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy got=%b exp=1", busy); end
        step(1'b1, 8'h83);
        checks++; if (frame_ok !== 1'b0) begin errors++; $display("FAIL good_early_ok got=%b exp=0", frame_ok); end
        step(1'b1, 8'h2E);
        checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL good_ok got=%b exp=1", frame_ok); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL good_err got=%b exp=0", frame_err); end
        checks++; if (flags !== 12'h801) begin errors++; $display("FAIL good_flags got=%h exp=801", flags); end
        checks++; if (feedback_leds !== 4'h1) begin errors++; $display("FAIL good_leds got=%h exp=1", feedback_leds); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_idle got=%b exp=0", busy); end
        step(1'b0, 8'h00);
        checks++; if (frame_ok !== 1'b0) begin errors++; $display("FAIL good_ok_pulse got=%b exp=0", frame_ok); end
        checks++; if (flags !== 12'h801) begin errors++; $display("FAIL good_hold got=%h exp=801", flags); end
    endtask

    task automatic test_bad_checksum;
        step(1'b1, 8'h05);
        step(1'b1, 8'h83);
        step(1'b1, 8'h32);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL bad_err got=%b exp=1", frame_err); end
        checks++; if (frame_ok !== 1'b0) begin errors++; $display("FAIL bad_ok got=%b exp=0", frame_ok); end
        checks++; if (flags !== 12'h801) begin errors++; $display("FAIL bad_flags got=%h exp=801", flags); end
        step(1'b0, 8'h00);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL bad_err_pulse got=%b exp=0", frame_err); end
    endtask

    task automatic test_timeout;
        step(1'b1, 8'h05);
        for (int i = 0; i < 25; i++) begin
            step(1'b0, 8'h00);
            checks++;
            if (frame_err !== (i == TO - 1)) begin
                errors++;
                $display("FAIL timeout_err idle=%0d got=%b exp=%b", i + 1, frame_err, (i == TO - 1));
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got=%b exp=0", busy); end
        step(1'b1, 8'h83);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL timeout_late_err got=%b exp=0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_late_busy got=%b exp=0", busy); end
    endtask

    task automatic test_restart;
        logic [7:0] end_byte;
        end_byte = {6'b000010 ^ 6'b100000 ^ 6'h2A, 2'b10};
        step(1'b1, 8'h05);
        step(1'b1, 8'h09);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL restart_err got=%b exp=1", frame_err); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got=%b exp=1", busy); end
        step(1'b1, 8'h83);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL restart_err_pulse got=%b exp=0", frame_err); end
        step(1'b1, end_byte);
        checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL restart_ok got=%b exp=1", frame_ok); end
        checks++; if (flags !== 12'h802) begin errors++; $display("FAIL restart_flags got=%h exp=802", flags); end
        checks++; if (feedback_leds !== 4'h2) begin errors++; $display("FAIL restart_leds got=%h exp=2", feedback_leds); end
    endtask

    task automatic test_filler;
        logic [7:0] seq [7];
        seq = '{8'h83, 8'h00, 8'h05, 8'h00, 8'h83, 8'h00, 8'h2E};
        for (int i = 0; i < 7; i++) begin
            step(1'b1, seq[i]);
            checks++;
            if (frame_err !== 1'b0) begin errors++; $display("FAIL filler_err byte=%0d got=%b exp=0", i, frame_err); end
        end
        checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL filler_ok got=%b exp=1", frame_ok); end
        checks++; if (flags !== 12'h801) begin errors++; $display("FAIL filler_flags got=%h exp=801", flags); end
    endtask

    task automatic test_random;
        logic [8:0] cyc[$];
        logic [7:0] fb[$];
        logic [5:0] c0, c1, ck, flip;
        int         kind, gap, n;
        for (int f = 0; f < 150; f++) begin
            fb.delete();
            cyc.delete();
            c0   = 6'($urandom);
            c1   = 6'($urandom);
            ck   = c0 ^ c1 ^ 6'h2A;
            flip = 6'(1 << $urandom_range(0, 5));
            kind = int'($urandom_range(0, 6));
            case (kind)
                0, 1, 2: begin
                    fb.push_back({c0, 2'b01}); fb.push_back({c1, 2'b11}); fb.push_back({ck, 2'b10});
                end
                3: begin
                    fb.push_back({c0, 2'b01}); fb.push_back({c1, 2'b11}); fb.push_back({ck ^ flip, 2'b10});
                end
                4: begin
                    n = int'($urandom_range(1, 4));
                    for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
                end
                5: begin
                    fb.push_back({c0, 2'b01}); fb.push_back({ck, 2'b10});
                end
                default: begin
                    fb.push_back({c0, 2'b01}); fb.push_back({c1, 2'b11});
                    fb.push_back({c1, 2'b11}); fb.push_back({ck, 2'b10});
                end
            endcase
            for (int i = 0; i < fb.size(); i++) begin
                gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 24)) : int'($urandom_range(0, 3));
                for (int g = 0; g < gap; g++) begin
                    if ($urandom_range(0, 1) == 1) cyc.push_back({1'b1, 6'($urandom), 2'b00});
                    else cyc.push_back(9'h000);
                end
                cyc.push_back({1'b1, fb[i]});
            end
            for (int j = 0; j < cyc.size(); j++) begin
                step(cyc[j][8], cyc[j][7:0]);
                checks++; if (frame_ok !== exp_ok) begin errors++; $display("FAIL rand_ok frame=%0d cyc=%0d got=%b exp=%b", f, j, frame_ok, exp_ok); end
                checks++; if (frame_err !== exp_err) begin errors++; $display("FAIL rand_err frame=%0d cyc=%0d got=%b exp=%b", f, j, frame_err, exp_err); end
                checks++; if (flags !== exp_flags) begin errors++; $display("FAIL rand_flags frame=%0d cyc=%0d got=%h exp=%h", f, j, flags, exp_flags); end
                checks++; if (feedback_leds !== exp_flags[LW-1:0]) begin errors++; $display("FAIL rand_leds frame=%0d cyc=%0d got=%h exp=%h", f, j, feedback_leds, exp_flags[LW-1:0]); end
                checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rand_busy frame=%0d cyc=%0d got=%b exp=%b", f, j, busy, exp_busy); end
                checks++; if (stale !== exp_stale) begin errors++; $display("FAIL rand_stale frame=%0d cyc=%0d got=%b exp=%b", f, j, stale, exp_stale); end
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        step(1'b1, 8'h05);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre got=%b exp=1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (flags !== 12'h000) begin errors++; $display("FAIL rstmid_flags got=%h exp=000", flags); end
        checks++; if (feedback_leds !== 4'h0) begin errors++; $display("FAIL rstmid_leds got=%h exp=0", feedback_leds); end
        checks++; if (frame_ok !== 1'b0) begin errors++; $display("FAIL rstmid_ok got=%b exp=0", frame_ok); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_err got=%b exp=0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL rstmid_stale got=%b exp=0", stale); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1'b1, 8'h83);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_cont_busy got=%b exp=0", busy); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_cont_err got=%b exp=0", frame_err); end
    endtask

    task automatic test_stale;
        int            seen_at;
        int            exp_at;
        logic [NF-1:0] exp_hold;
        seen_at  = -1;
        exp_at   = STALE_EN ? SC - 1 : -1;
        exp_hold = STALE_EN ? 12'h000 : 12'h801;
        do_reset();
        step(1'b1, 8'h05);
        step(1'b1, 8'h83);
        step(1'b1, 8'h2E);
        checks++; if (flags !== 12'h801) begin errors++; $display("FAIL stale_pre_flags got=%h exp=801", flags); end
        for (int i = 0; i < SC + 10; i++) begin
            step(1'b0, 8'h00);
            if (stale === 1'b1 && seen_at < 0) seen_at = i;
            checks++; if (stale !== exp_stale) begin errors++; $display("FAIL stale_track cyc=%0d got=%b exp=%b", i, stale, exp_stale); end
            checks++; if (flags !== exp_flags) begin errors++; $display("FAIL stale_flags cyc=%0d got=%h exp=%h", i, flags, exp_flags); end
        end
        checks++; if (seen_at !== exp_at) begin errors++; $display("FAIL stale_onset got=%0d exp=%0d", seen_at, exp_at); end
        checks++; if (flags !== exp_hold) begin errors++; $display("FAIL stale_hold got=%h exp=%h", flags, exp_hold); end
        checks++; if (stale !== STALE_EN) begin errors++; $display("FAIL stale_level got=%b exp=%b", stale, STALE_EN); end
        step(1'b1, 8'h05);
        step(1'b1, 8'h83);
        step(1'b1, 8'h2E);
        checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL stale_recover_ok got=%b exp=1", frame_ok); end
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL stale_recover got=%b exp=0", stale); end
        checks++; if (flags !== 12'h801) begin errors++; $display("FAIL stale_recover_flags got=%h exp=801", flags); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_timeout();
        test_restart();
        test_filler();
        test_random();
        test_reset_mid_frame();
        test_stale();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
